dmem_responder: RTL and testbench

- Memory-side responder for the executor's data interface.
- Accepts load/store requests (address, write_data, write_data_sig) and returns read_data with a combinational wait_sig stall.
- Drives a single-port synchronous SRAM with configurable read latency.
- Stores are read-modify-write: the old word is returned on read_data first, so the executor can merge SB/SH data before the full-word write.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_sram.sv | 34 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t  - responder FSM states
//   STATE_W  - encoded state width
//   WORD_OFS - byte-to-word address shift
package dmem_pkg;

  localparam int STATE_W  = 3;
  localparam int WORD_OFS = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: behavioural single-port synchronous RAM with a LATENCY-stage
// read pipeline. Used by simulation benches and FPGA builds.
//   clk   - clock
//   en    - access enable
//   we    - write enable (qualified by en)
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid LATENCY cycles after a read enable
module dmem_sram #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem  [2**ADDR_W];
  logic [31:0] pipe [LATENCY];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    pipe[0]   <= mem[addr];
    end
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the executor data interface.
// Loads read one word; stores are read-modify-write (old word returned on
// read_data first, then the executor's merged write_data is written).
//
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned accesses skip the
// SRAM, return 0 and pulse fault in the DONE cycle.
//
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   req             - load/store present
//   address         - byte address (word index = address[ADDR_W+1:2])
//   write_data      - merged store word, used in WR
//   write_data_sig  - 1 store / 0 load, sampled at acceptance
//   read_data       - registered SRAM word
//   wait_sig        - combinational stall to the executor
//   fault           - misalignment pulse (feature only)
//   mem_*           - single-port SRAM interface
//
// state | meaning
// IDLE  | waiting for req, latch index and direction
// RD    | issue SRAM read, load latency counter
// RWAIT | count down read latency, capture mem_rdata at 0
// WR    | write merged word back (stores only)
// DONE  | wait_sig low for one cycle so the executor commits
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  input  logic              write_data_sig,
  output logic [31:0]       read_data,
  output logic              wait_sig,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                mis_q, mis_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_d;

  // High address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^address[31:ADDR_W+WORD_OFS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      cnt_q     <= '0;
      read_data <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      cnt_q     <= cnt_d;
      read_data <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    mis_d     = mis_q;
    cnt_d     = cnt_q;
    rdata_d   = read_data;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = address[ADDR_W+WORD_OFS-1:WORD_OFS];
          we_d   = write_data_sig;
          mis_d  = MISALIGN_EN && (address[1:0] != 2'b00);
          if (mis_d) begin
            rdata_d = '0;
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_en = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = we_q ? WR : DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        // Write completes even if req has already dropped.
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = write_data;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign wait_sig = req & (state_q != DONE);
  assign fault    = MISALIGN_EN & mis_q & (state_q == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v   [2];
  logic [31:0] addr_v  [2];
  logic        we_v    [2];
  logic [31:0] wd_full [2];
  logic [31:0] wd0, wd1;
  logic        merge;
  logic [31:0] rd_v    [2];
  logic        wait_v  [2];
  logic        fault_v [2];
  logic        en_v    [2];
  logic        mwe_v   [2];
  logic [9:0]  maddr_v [2];
  logic [31:0] mwd_v   [2];
  logic [31:0] mrd_v   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Executor model: SB merge replaces the low byte of the returned old word.
  assign wd0 = merge ? {rd_v[0][31:8], 8'hAA} : wd_full[0];
  assign wd1 = wd_full[1];

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .address(addr_v[0]),
    .write_data(wd0), .write_data_sig(we_v[0]), .read_data(rd_v[0]),
    .wait_sig(wait_v[0]), .fault(fault_v[0]), .mem_en(en_v[0]),
    .mem_we(mwe_v[0]), .mem_addr(maddr_v[0]), .mem_wdata(mwd_v[0]),
    .mem_rdata(mrd_v[0]));

  dmem_sram #(.ADDR_W(10), .LATENCY(1)) u_sram1 (
    .clk(clk), .en(en_v[0]), .we(mwe_v[0]), .addr(maddr_v[0]),
    .wdata(mwd_v[0]), .rdata(mrd_v[0]));

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .address(addr_v[1]),
    .write_data(wd1), .write_data_sig(we_v[1]), .read_data(rd_v[1]),
    .wait_sig(wait_v[1]), .fault(fault_v[1]), .mem_en(en_v[1]),
    .mem_we(mwe_v[1]), .mem_addr(maddr_v[1]), .mem_wdata(mwd_v[1]),
    .mem_rdata(mrd_v[1]));

  dmem_sram #(.ADDR_W(10), .LATENCY(3)) u_sram3 (
    .clk(clk), .en(en_v[1]), .we(mwe_v[1]), .addr(maddr_v[1]),
    .wdata(mwd_v[1]), .rdata(mrd_v[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access on DUT d; samples on the falling edge.
  task automatic do_access(input int d, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output int stall, output int en_c, output int we_c,
                           output logic [31:0] wlast, output logic [9:0] alast,
                           output int flt);
    bit done = 0;
    rd = '0; stall = 0; en_c = 0; we_c = 0; wlast = '0; alast = '0; flt = 0;
    @(posedge clk); #1;
    req_v[d] = 1'b1; addr_v[d] = a; we_v[d] = we; wd_full[d] = wd;
    for (int g = 0; g < 20 && !done; g++) begin
      @(negedge clk);
      if (en_v[d]) begin en_c++; alast = maddr_v[d]; end
      if (mwe_v[d]) begin we_c++; wlast = mwd_v[d]; end
      if (fault_v[d]) flt++;
      if (!wait_v[d]) begin done = 1; rd = rd_v[d]; end
      else stall++;
    end
    chk("access_completes", 32'(done), 32'd1);
    @(posedge clk); #1;
    req_v[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd, wl;
    logic [9:0]  al;
    int st, ec, wc, fc;

    vecs[0]  = '{0, 1'b1, 32'h0000_0014, 32'hDEADBEEF, 1'b0, 32'h0,         4};
    vecs[1]  = '{0, 1'b1, 32'h0000_000C, 32'h11223344, 1'b0, 32'h0,         4};
    vecs[2]  = '{0, 1'b0, 32'h0000_0014, 32'h0,        1'b1, 32'hDEADBEEF, 3};
    vecs[3]  = '{0, 1'b0, 32'h0000_000C, 32'h0,        1'b1, 32'h11223344, 3};
    vecs[4]  = '{0, 1'b1, 32'h0000_1010, 32'hCAFEF00D, 1'b0, 32'h0,         4};
    vecs[5]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'hCAFEF00D, 3};
    vecs[6]  = '{0, 1'b1, 32'h0000_0014, 32'h01234567, 1'b1, 32'hDEADBEEF, 4};
    vecs[7]  = '{0, 1'b0, 32'h0000_0014, 32'h0,        1'b1, 32'h01234567, 3};
    vecs[8]  = '{1, 1'b1, 32'h0000_0020, 32'h55AA55AA, 1'b0, 32'h0,         6};
    vecs[9]  = '{1, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h55AA55AA, 5};
    vecs[10] = '{1, 1'b0, 32'hFFFF_F020, 32'h0,        1'b1, 32'h55AA55AA, 5};

    merge = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; addr_v[d] = '0; we_v[d] = 1'b0; wd_full[d] = '0;
    end
    rst_n = 1'b0;
    #23;
    for (int d = 0; d < 2; d++) begin
      chk("rst_read_data", rd_v[d], 32'h0);
      chk("rst_mem_en",    32'(en_v[d]), 32'h0);
      chk("rst_mem_we",    32'(mwe_v[d]), 32'h0);
      chk("rst_mem_addr",  32'(maddr_v[d]), 32'h0);
      chk("rst_mem_wdata", mwd_v[d], 32'h0);
      chk("rst_fault",     32'(fault_v[d]), 32'h0);
      chk("rst_wait",      32'(wait_v[d]), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].d, vecs[i].addr, vecs[i].we, vecs[i].wdata,
                rd, st, ec, wc, wl, al, fc);
      chk($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_en_cycles", i), 32'(ec), vecs[i].we ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_we_cycles", i), 32'(wc), vecs[i].we ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_mem_addr", i), 32'(al), 32'(vecs[i].addr[11:2]));
      chk($sformatf("v%0d_fault", i), 32'(fc), 32'd0);
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), wl, vecs[i].wdata);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_read_data", i), rd, vecs[i].exp_rd);
    end

    // Store-byte merge: executor replaces low byte of the old word.
    merge = 1'b1;
    do_access(0, 32'h0000_000C, 1'b1, 32'h0, rd, st, ec, wc, wl, al, fc);
    merge = 1'b0;
    chk("sb_we_cycles", 32'(wc), 32'd1);
    chk("sb_wdata", wl, 32'h112233AA);
    do_access(0, 32'h0000_000C, 1'b0, 32'h0, rd, st, ec, wc, wl, al, fc);
    chk("sb_readback", rd, 32'h112233AA);

    // Reset in RWAIT of a store: no write, outputs cleared at once.
    @(posedge clk); #1;
    req_v[0] = 1'b1; addr_v[0] = 32'h0000_000C; we_v[0] = 1'b1; wd_full[0] = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_in_rwait_wait", 32'(wait_v[0]), 32'd1);
    rst_n = 1'b0; req_v[0] = 1'b0;
    #1;
    chk("midrst_read_data", rd_v[0], 32'h0);
    chk("midrst_mem_en",    32'(en_v[0]), 32'h0);
    chk("midrst_mem_we",    32'(mwe_v[0]), 32'h0);
    chk("midrst_mem_addr",  32'(maddr_v[0]), 32'h0);
    chk("midrst_wait",      32'(wait_v[0]), 32'h0);
    wc = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (mwe_v[0]) wc++;
    end
    rst_n = 1'b1;
    chk("midrst_no_write", 32'(wc), 32'd0);
    do_access(0, 32'h0000_000C, 1'b0, 32'h0, rd, st, ec, wc, wl, al, fc);
    chk("postrst_readback", rd, 32'h112233AA);
    chk("postrst_stall", 32'(st), 32'd3);

    // req drops in RWAIT of a store: abort, no write, read_data kept.
    @(posedge clk); #1;
    req_v[0] = 1'b1; addr_v[0] = 32'h0000_0014; we_v[0] = 1'b1; wd_full[0] = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    wc = 0;
    @(negedge clk);
    chk("drop_wait", 32'(wait_v[0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (mwe_v[0]) wc++;
      @(negedge clk);
    end
    chk("drop_no_write", 32'(wc), 32'd0);
    chk("drop_read_data_kept", rd_v[0], 32'h112233AA);
    do_access(0, 32'h0000_0014, 1'b0, 32'h0, rd, st, ec, wc, wl, al, fc);
    chk("drop_word_unchanged", rd, 32'h01234567);

    // Misaligned load on word 5.
    do_access(0, 32'h0000_0016, 1'b0, 32'h0, rd, st, ec, wc, wl, al, fc);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis_stall", 32'(st), 32'd1);
    chk("mis_fault_cycles", 32'(fc), 32'd1);
    chk("mis_en_cycles", 32'(ec), 32'd0);
    chk("mis_read_data", rd, 32'h0);
`else
    chk("mis_stall", 32'(st), 32'd3);
    chk("mis_fault_cycles", 32'(fc), 32'd0);
    chk("mis_en_cycles", 32'(ec), 32'd1);
    chk("mis_read_data", rd, 32'h01234567);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
